universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, shift-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  clock enable; 0 = hold all state.
REQ-006 SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port si_r  input  1  serial in, enters MSB on right shift.
REQ-008 SHALL have port si_l  input  1  serial in, enters LSB on left shift.
REQ-009 SHALL have port pin  input  WIDTH  parallel load data.
REQ-010 SHALL have port pout  output  WIDTH  register contents q.
REQ-011 SHALL have port so_r  output  1  serial out, equals q[0].
REQ-012 SHALL have port so_l  output  1  serial out, equals q[WIDTH-1].
REQ-013 SHALL have port done  output  1  registered one-cycle pulse, WIDTH shifts completed since last load/reset.

Function
REQ-014 Right shift (en=1, mode=01) SHALL set q <= {si_r, q[WIDTH-1:1]}.
REQ-015 Left shift (en=1, mode=10) SHALL set q <= {q[WIDTH-2:0], si_l}.
REQ-016 Load (en=1, mode=11) SHALL set q <= pin and count <= 0 in the same edge; done <= 0.
REQ-017 Hold (mode=00 or en=0) SHALL keep q and count unchanged; done <= 0.
REQ-018 so_r/so_l/pout SHALL be direct from q (no extra register); si_r-to-so_r latency = WIDTH shift edges (SISO behaviour).
REQ-019 count SHALL increment on every shift edge, either direction; direction change mid-frame does not clear it.
REQ-020 On a shift edge with count == WIDTH-1, count SHALL wrap to 0 and done SHALL be 1 for exactly the following cycle.
REQ-021 Back-to-back frames: continuous shifting SHALL produce done every WIDTH shift edges with no gap cycle.
REQ-022 Load with count == WIDTH-1 SHALL NOT produce done; load has priority over counting.
REQ-023 en=0 during a frame SHALL freeze the frame; done still requires WIDTH shift edges total.
REQ-024 No combinational path from any input to any output.

Reset
REQ-025 clear=1 at a rising edge SHALL set q=0, count=0, done=0, overriding en and mode.
REQ-026 After clear, pout=0, so_r=0, so_l=0, done=0 until the next enabled operation.
REQ-027 clear mid-frame SHALL discard the partial frame; the next done needs WIDTH fresh shifts.

Structure
REQ-028 Mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) SHALL live in shared package shift_pkg.
REQ-029 The shift counter and done generation SHALL be a sub-module shift_cnt (inputs clk, clear, inc, zero; outputs done).
REQ-030 Data path (q register, mode mux) SHALL stay in universal_shift_reg.

Verification
REQ-031 WIDTH=8: clear, load pin=0xA5, 8 right shifts si_r=0 -> so_r sequence 1,0,1,0,0,1,0,1; pout=0x00; done high one cycle after 8th shift.
REQ-032 WIDTH=8: load 0x81, 8 left shifts si_l=1 -> so_l sequence 1,0,0,0,0,0,0,1; final pout=0xFF; one done pulse.
REQ-033 SISO check: clear, si_r pattern 1,0,0,1,0 one bit per cycle, mode=01 -> same pattern on so_r starting 8 edges later.
REQ-034 en toggled low for 3 cycles after 4 shifts -> q and count frozen; done only after 4 further shifts.
REQ-035 clear asserted after 5 shifts, and load asserted when count=7 -> no done pulse, q=0 / q=pin respectively, count restarts at 0.
REQ-036 WIDTH=2 and WIDTH=64 continuous right shifting -> done every 2 / 64 cycles, no missed or extra pulses.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation-select encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // True for the two modes that move data by one bit position.
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Frame counter: counts shift edges in either direction and emits a registered
// one-cycle done pulse on the edge that completes WIDTH shifts.
module shift_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  input  logic zero,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  // Count state and done pulse; zero (load) outranks inc so a load on the
  // last count position never produces a pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (zero) begin
      count <= '0;
      done  <= 1'b0;
    end else if (inc) begin
      if (count == LAST) begin
        count <= '0;
        done  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with serial outputs taken straight from the register and a frame-done pulse.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so_r,
  output logic             so_l,
  output logic             done
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             inc;
  logic             zero;

  assign mode_sel = mode_e'(mode);

  // Mode mux: next register value for an enabled edge.
  always_comb begin
    q_next = q;
    case (mode_sel)
      MODE_SHR:  q_next = {si_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], si_l};
      MODE_LOAD: q_next = pin;
      default:   q_next = q;
    endcase
  end

  // Data register; clear overrides enable and mode.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

  assign inc  = en && is_shift(mode_sel);
  assign zero = en && (mode_sel == MODE_LOAD);

  shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (inc),
    .zero  (zero),
    .done  (done)
  );

  // Outputs come straight from registers, so no input reaches an output
  // without passing a clock edge.
  assign pout = q;
  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed testbench for universal_shift_reg at WIDTH=8, 2 and 64.
module tb_universal_shift_reg;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = M_HOLD;
  logic        si_r = 1'b0;
  logic        si_l = 1'b0;

  logic [7:0]  pin8 = '0;
  logic [7:0]  pout8;
  logic        so_r8, so_l8, done8;

  logic [1:0]  pin2 = '0;
  logic [1:0]  pout2;
  logic        so_r2, so_l2, done2;

  logic [63:0] pin64 = '0;
  logic [63:0] pout64;
  logic        so_r64, so_l64, done64;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .pin(pin8), .pout(pout8), .so_r(so_r8), .so_l(so_l8), .done(done8)
  );

  universal_shift_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .pin(pin2), .pout(pout2), .so_r(so_r2), .so_l(so_l2), .done(done2)
  );

  universal_shift_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .pin(pin64), .pout(pout64), .so_r(so_r64), .so_l(so_l64), .done(done64)
  );

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    si_r = 1'b1; si_l = 1'b1; en = 1'b1; mode = M_LOAD; pin8 = 8'hFF; pin64 = '1;
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0; mode = M_HOLD;
    checks++; if (pout8 !== 8'h00) $display("FAIL reset_pout8 got %h want 00", pout8); else passed++;
    checks++; if (so_r8 !== 1'b0) $display("FAIL reset_so_r got %b want 0", so_r8); else passed++;
    checks++; if (so_l8 !== 1'b0) $display("FAIL reset_so_l got %b want 0", so_l8); else passed++;
    checks++; if (done8 !== 1'b0) $display("FAIL reset_done got %b want 0", done8); else passed++;
    checks++; if (pout64 !== 64'h0) $display("FAIL reset_pout64 got %h want 0", pout64); else passed++;
    tick();
    checks++; if (pout8 !== 8'h00 || done8 !== 1'b0)
      $display("FAIL reset_hold got pout=%h done=%b want 00/0", pout8, done8); else passed++;
  endtask

  task automatic test_right_shift();
    logic [7:0] seq;
    seq = 8'hA5;
    do_clear();
    en = 1'b1; mode = M_LOAD; pin8 = 8'hA5;
    tick();
    checks++; if (pout8 !== 8'hA5) $display("FAIL shr_load got %h want a5", pout8); else passed++;
    mode = M_SHR; si_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (so_r8 !== seq[i]) $display("FAIL shr_so_r[%0d] got %b want %b", i, so_r8, seq[i]); else passed++;
      tick();
      checks++; if (done8 !== (i == 7)) $display("FAIL shr_done[%0d] got %b want %b", i, done8, (i == 7)); else passed++;
    end
    checks++; if (pout8 !== 8'h00) $display("FAIL shr_final got %h want 00", pout8); else passed++;
    mode = M_HOLD;
    tick();
    checks++; if (done8 !== 1'b0) $display("FAIL shr_done_one_cycle got %b want 0", done8); else passed++;
  endtask

  task automatic test_left_shift();
    logic [7:0] seq;
    int pulses;
    seq = 8'h81;
    pulses = 0;
    en = 1'b1; mode = M_LOAD; pin8 = 8'h81;
    tick();
    mode = M_SHL; si_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (so_l8 !== seq[i]) $display("FAIL shl_so_l[%0d] got %b want %b", i, so_l8, seq[i]); else passed++;
      tick();
      if (done8) pulses++;
    end
    checks++; if (pout8 !== 8'hFF) $display("FAIL shl_final got %h want ff", pout8); else passed++;
    checks++; if (pulses !== 1) $display("FAIL shl_pulses got %0d want 1", pulses); else passed++;
    checks++; if (done8 !== 1'b1) $display("FAIL shl_done_at_8 got %b want 1", done8); else passed++;
    mode = M_HOLD;
    tick();
    checks++; if (done8 !== 1'b0) $display("FAIL shl_done_drop got %b want 0", done8); else passed++;
  endtask

  task automatic test_siso();
    logic [4:0] pat;
    pat = 5'b01001;
    do_clear();
    en = 1'b1; mode = M_SHR;
    for (int e = 1; e <= 12; e++) begin
      si_r = (e <= 5) ? pat[e-1] : 1'b0;
      tick();
      if (e >= 8) begin
        checks++; if (so_r8 !== pat[e-8]) $display("FAIL siso_bit[%0d] got %b want %b", e - 8, so_r8, pat[e-8]); else passed++;
      end
      checks++; if (done8 !== (e == 8)) $display("FAIL siso_done[%0d] got %b want %b", e, done8, (e == 8)); else passed++;
    end
  endtask

  task automatic test_enable();
    do_clear();
    en = 1'b1; mode = M_SHR; si_r = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (pout8 !== 8'hF0) $display("FAIL en_pre got %h want f0", pout8); else passed++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pout8 !== 8'hF0 || done8 !== 1'b0)
        $display("FAIL en_frozen[%0d] got pout=%h done=%b want f0/0", i, pout8, done8); else passed++;
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (done8 !== (i == 3)) $display("FAIL en_resume_done[%0d] got %b want %b", i, done8, (i == 3)); else passed++;
    end
    checks++; if (pout8 !== 8'hFF) $display("FAIL en_final got %h want ff", pout8); else passed++;
  endtask

  task automatic test_clear_load();
    int pulses;
    do_clear();
    en = 1'b1; mode = M_SHR; si_r = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (pout8 !== 8'h00 || done8 !== 1'b0)
      $display("FAIL clr_mid got pout=%h done=%b want 00/0", pout8, done8); else passed++;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done8) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL clr_no_early_done got %0d want 0", pulses); else passed++;
    tick();
    checks++; if (done8 !== 1'b1) $display("FAIL clr_fresh_done got %b want 1", done8); else passed++;
    for (int i = 0; i < 7; i++) tick();
    mode = M_LOAD; pin8 = 8'h3C;
    tick();
    checks++; if (pout8 !== 8'h3C || done8 !== 1'b0)
      $display("FAIL load_at_7 got pout=%h done=%b want 3c/0", pout8, done8); else passed++;
    mode = M_SHR; si_r = 1'b0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done8) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL load_restart_early got %0d want 0", pulses); else passed++;
    tick();
    checks++; if (done8 !== 1'b1) $display("FAIL load_restart_done got %b want 1", done8); else passed++;
  endtask

  task automatic test_back_to_back();
    do_clear();
    en = 1'b1; si_r = 1'b0; si_l = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      mode = (e <= 4 || (e > 8 && e <= 12)) ? M_SHR : M_SHL;
      tick();
      checks++; if (done8 !== (e == 8 || e == 16))
        $display("FAIL b2b_done[%0d] got %b want %b", e, done8, (e == 8 || e == 16)); else passed++;
    end
  endtask

  task automatic test_widths();
    int p2, p64, bad;
    p2 = 0; p64 = 0; bad = 0;
    do_clear();
    en = 1'b1; mode = M_SHR;
    for (int e = 1; e <= 130; e++) begin
      si_r = e[0];
      tick();
      if (done2) p2++;
      if (done64) p64++;
      if (done2 !== ((e % 2) == 0)) bad++;
      if (done64 !== ((e % 64) == 0)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL width_done_positions got %0d misplaced want 0", bad); else passed++;
    checks++; if (p2 !== 65) $display("FAIL width2_pulses got %0d want 65", p2); else passed++;
    checks++; if (p64 !== 2) $display("FAIL width64_pulses got %0d want 2", p64); else passed++;
    mode = M_HOLD;
  endtask

  initial begin
    tick();
    test_reset();
    test_right_shift();
    test_left_shift();
    test_siso();
    test_enable();
    test_clear_load();
    test_back_to_back();
    test_widths();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
